// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command issuer: opcode encoding, datapath
// width and a small helper that zeroes a data word when its stage is empty.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 2;

    typedef enum logic [OP_W-1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        MUL = 2'd2,
        RSV = 2'd3
    } alu_op_e;

    // Forces a data word to zero when the owning stage holds nothing valid.
    function automatic logic [DATA_W-1:0] gate_data(input logic en, input logic [DATA_W-1:0] d);
        return en ? d : '0;
    endfunction

endpackage

// File: rtl/rsp_fifo.sv
// Small response queue between the issue stage and the consumer. Holds the
// ALU result together with its caller tag; entries leave in arrival order.
module rsp_fifo
    import alu_pkg::*;
#(
    parameter int TAG_W = 4,
    parameter int DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic [TAG_W-1:0]  push_tag,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic [TAG_W-1:0]  head_tag,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [TAG_W-1:0]  tag_mem  [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              do_push;
    logic              do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    // A pop frees a slot in the same cycle, so a push into a full queue is
    // legal when it coincides with a pop.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign head_data = data_mem[rd_ptr];
    assign head_tag  = tag_mem[rd_ptr];

    // Storage write; payload carries no reset, only the pointers qualify it.
    always_ff @(posedge clock) begin
        if (do_push) begin
            data_mem[wr_ptr] <= push_data;
            tag_mem[wr_ptr]  <= push_tag;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_issuer.sv
// Single-entry issue stage in front of an external combinational ALU. A
// registered command drives the ALU; its result is captured with the tag
// into the response queue. Sustains one command per cycle while the
// response queue drains.
module alu_issuer
    import alu_pkg::*;
#(
    parameter int TAG_W     = 4,
    parameter int RSP_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_cmd_valid,
    output logic              io_cmd_ready,
    input  logic [DATA_W-1:0] io_cmd_A,
    input  logic [DATA_W-1:0] io_cmd_B,
    input  logic [OP_W-1:0]   io_cmd_op,
    input  logic [TAG_W-1:0]  io_cmd_tag,
    output logic [DATA_W-1:0] io_alu_A,
    output logic [DATA_W-1:0] io_alu_B,
    output logic [OP_W-1:0]   io_alu_op,
    input  logic [DATA_W-1:0] io_alu_out,
    output logic              io_rsp_valid,
    input  logic              io_rsp_ready,
    output logic [DATA_W-1:0] io_rsp_data,
    output logic [TAG_W-1:0]  io_rsp_tag,
    output logic [15:0]       io_issued
);

    logic              vld_p0;
    logic [DATA_W-1:0] a_p0;
    logic [DATA_W-1:0] b_p0;
    alu_op_e           op_p0;
    logic [TAG_W-1:0]  tag_p0;

    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] head_data;
    logic [TAG_W-1:0]  head_tag;
    logic              rsp_pop;
    logic              issue_done;
    logic              cmd_fire;

    assign rsp_pop      = !fifo_empty && io_rsp_ready;
    // A full queue still has room this cycle if the consumer is popping.
    assign issue_done   = vld_p0 && (!fifo_full || rsp_pop);
    assign io_cmd_ready = !vld_p0 || issue_done;
    assign cmd_fire     = io_cmd_valid && io_cmd_ready;

    // The ALU sees zeros whenever the issue stage is empty.
    assign io_alu_A  = gate_data(vld_p0, a_p0);
    assign io_alu_B  = gate_data(vld_p0, b_p0);
    assign io_alu_op = vld_p0 ? op_p0 : ADD;

    // Responses come only from the queue head; the issue stage never bypasses.
    assign io_rsp_valid = !fifo_empty;
    assign io_rsp_data  = gate_data(!fifo_empty, head_data);
    assign io_rsp_tag   = fifo_empty ? '0 : head_tag;

    // Issue stage occupancy: filled by an accepted command, emptied on issue.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_p0 <= 1'b0;
        end else if (cmd_fire) begin
            vld_p0 <= 1'b1;
        end else if (issue_done) begin
            vld_p0 <= 1'b0;
        end
    end

    // Issue stage payload; held while stalled so the ALU inputs stay put.
    always_ff @(posedge clock) begin
        if (cmd_fire) begin
            a_p0   <= io_cmd_A;
            b_p0   <= io_cmd_B;
            op_p0  <= alu_op_e'(io_cmd_op);
            tag_p0 <= io_cmd_tag;
        end
    end

    // Count of completed issues, wrapping naturally at 16 bits.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            io_issued <= '0;
        end else if (issue_done) begin
            io_issued <= io_issued + 16'd1;
        end
    end

    rsp_fifo #(
        .TAG_W (TAG_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (issue_done),
        .push_data (io_alu_out),
        .push_tag  (tag_p0),
        .pop       (rsp_pop),
        .head_data (head_data),
        .head_tag  (head_tag),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_alu_issuer.sv
// Bench for alu_issuer: behavioural external ALU, a queue-based scoreboard,
// a table of directed vectors, hand sequences for stall/reset/wrap cases and
// a randomized run.
module tb_alu_issuer;
    import alu_pkg::*;

    localparam int TAG_W     = 4;
    localparam int RSP_DEPTH = 2;

    logic              clock;
    logic              reset;
    logic              io_cmd_valid;
    logic              io_cmd_ready;
    logic [31:0]       io_cmd_A;
    logic [31:0]       io_cmd_B;
    logic [1:0]        io_cmd_op;
    logic [TAG_W-1:0]  io_cmd_tag;
    logic [31:0]       io_alu_A;
    logic [31:0]       io_alu_B;
    logic [1:0]        io_alu_op;
    logic [31:0]       io_alu_out;
    logic              io_rsp_valid;
    logic              io_rsp_ready;
    logic [31:0]       io_rsp_data;
    logic [TAG_W-1:0]  io_rsp_tag;
    logic [15:0]       io_issued;

    alu_issuer #(.TAG_W(TAG_W), .RSP_DEPTH(RSP_DEPTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_cmd_valid (io_cmd_valid),
        .io_cmd_ready (io_cmd_ready),
        .io_cmd_A     (io_cmd_A),
        .io_cmd_B     (io_cmd_B),
        .io_cmd_op    (io_cmd_op),
        .io_cmd_tag   (io_cmd_tag),
        .io_alu_A     (io_alu_A),
        .io_alu_B     (io_alu_B),
        .io_alu_op    (io_alu_op),
        .io_alu_out   (io_alu_out),
        .io_rsp_valid (io_rsp_valid),
        .io_rsp_ready (io_rsp_ready),
        .io_rsp_data  (io_rsp_data),
        .io_rsp_tag   (io_rsp_tag),
        .io_issued    (io_issued)
    );

    // External ALU
    always_comb begin
        io_alu_out = '0;
        case (io_alu_op)
            2'd0:    io_alu_out = io_alu_A + io_alu_B;
            2'd1:    io_alu_out = io_alu_A - io_alu_B;
            2'd2:    io_alu_out = io_alu_A * io_alu_B;
            default: io_alu_out = '0;
        endcase
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
    } exp_t;

    typedef struct {
        logic [31:0]      a;
        logic [31:0]      b;
        logic [1:0]       op;
        logic [TAG_W-1:0] tag;
        logic [31:0]      exp;
    } vec_t;

    exp_t             exp_q[$];
    int               n_pass;
    int               n_total;
    bit               sb_on;
    int               cmd_fires;
    bit               last_cmd_fire;
    bit               last_rsp_fire;
    bit               last_ready;
    bit               last_rsp_valid;
    logic [31:0]      last_rsp_data;
    logic [TAG_W-1:0] last_rsp_tag;
    bit               hold_pend;
    logic [31:0]      hold_data;
    logic [TAG_W-1:0] hold_tag;

    // Reference: result as the caller expects it, computed in 64-bit arithmetic.
    function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                               input logic [1:0] op);
        logic [63:0] wide;
        case (op)
            2'd0:    wide = {32'd0, a} + {32'd0, b};
            2'd1:    wide = {32'd0, a} + {32'd0, ~b} + 64'd1;
            2'd2:    wide = {32'd0, a} * {32'd0, b};
            default: wide = 64'd0;
        endcase
        return wide[31:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // One clock: sample at the falling edge, run the scoreboard, then step past the rising edge.
    task automatic cyc();
        bit   cf;
        bit   rf;
        exp_t e;
        @(negedge clock);
        cf = io_cmd_valid && io_cmd_ready;
        rf = io_rsp_valid && io_rsp_ready;
        last_cmd_fire  = cf;
        last_rsp_fire  = rf;
        last_ready     = io_cmd_ready;
        last_rsp_valid = io_rsp_valid;
        last_rsp_data  = io_rsp_data;
        last_rsp_tag   = io_rsp_tag;
        if (cf) cmd_fires++;
        if (sb_on) begin
            check("cmd_ready", io_cmd_ready, (exp_q.size() < RSP_DEPTH + 1) || rf);
            if (hold_pend) begin
                check("hold_valid", io_rsp_valid, 1'b1);
                check("hold_data", io_rsp_data, hold_data);
                check("hold_tag", io_rsp_tag, hold_tag);
            end
            hold_pend = io_rsp_valid && !io_rsp_ready;
            hold_data = io_rsp_data;
            hold_tag  = io_rsp_tag;
            if (rf) begin
                check("rsp_outstanding", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("rsp_data", io_rsp_data, e.data);
                    check("rsp_tag", io_rsp_tag, e.tag);
                end
            end
            if (cf) begin
                e.data = ref_result(io_cmd_A, io_cmd_B, io_cmd_op);
                e.tag  = io_cmd_tag;
                exp_q.push_back(e);
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic set_cmd(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                           input logic [TAG_W-1:0] tag);
        io_cmd_A   = a;
        io_cmd_B   = b;
        io_cmd_op  = op;
        io_cmd_tag = tag;
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        exp_q.delete();
        hold_pend = 0;
        cmd_fires = 0;
        @(posedge clock);
        #1;
    endtask

    task automatic drain(input string name);
        io_cmd_valid = 1'b0;
        io_rsp_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) cyc();
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vt[8];

    initial begin
        n_pass = 0; n_total = 0; sb_on = 1; cmd_fires = 0; hold_pend = 0;
        io_cmd_valid = 1'b0; io_rsp_ready = 1'b0;
        set_cmd(32'd0, 32'd0, 2'd0, '0);

        vt[0] = '{32'd5,          32'd3,          2'd0, 4'd1,  32'd8};
        vt[1] = '{32'hFFFFFFFF,   32'd1,          2'd0, 4'd5,  32'h00000000};
        vt[2] = '{32'd0,          32'd1,          2'd1, 4'd6,  32'hFFFFFFFF};
        vt[3] = '{32'h80000000,   32'd1,          2'd1, 4'd7,  32'h7FFFFFFF};
        vt[4] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   2'd2, 4'd8,  32'h00000001};
        vt[5] = '{32'h00012345,   32'h00000100,   2'd2, 4'd9,  32'h01234500};
        vt[6] = '{32'hDEADBEEF,   32'd1,          2'd3, 4'd10, 32'h00000000};
        vt[7] = '{32'h7FFFFFFF,   32'd1,          2'd0, 4'd15, 32'h80000000};

        // Reset state, checked while reset is held.
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_rsp_valid", io_rsp_valid, 1'b0);
        check("rst_cmd_ready", io_cmd_ready, 1'b1);
        check("rst_issued", io_issued, 16'd0);
        check("rst_alu_A", io_alu_A, 32'd0);
        check("rst_alu_op", io_alu_op, 2'd0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Directed vectors: one at a time, latency and result checked.
        io_rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            io_cmd_valid = 1'b1;
            set_cmd(vt[i].a, vt[i].b, vt[i].op, vt[i].tag);
            cyc();
            check("tbl_accept", last_cmd_fire, 1'b1);
            io_cmd_valid = 1'b0;
            cyc();
            check("tbl_no_bypass", last_rsp_valid, 1'b0);
            check("tbl_rsp_valid", io_rsp_valid, 1'b1);
            check("tbl_rsp_data", io_rsp_data, vt[i].exp);
            check("tbl_rsp_tag", io_rsp_tag, vt[i].tag);
            check("tbl_issued", io_issued, i + 1);
            cyc();
            check("tbl_rsp_gone", io_rsp_valid, 1'b0);
        end

        // Back-to-back commands, responses on consecutive cycles.
        io_cmd_valid = 1'b1;
        set_cmd(32'd3, 32'd5, 2'd1, 4'd2);       cyc();
        set_cmd(32'h10000, 32'h10000, 2'd2, 4'd3); cyc();
        set_cmd(32'd7, 32'd7, 2'd3, 4'd4);       cyc();
        io_cmd_valid = 1'b0;
        check("b2b_r0_fire", last_rsp_fire, 1'b1);
        check("b2b_r0_data", last_rsp_data, 32'hFFFFFFFE);
        check("b2b_r0_tag", last_rsp_tag, 4'd2);
        cyc();
        check("b2b_r1_fire", last_rsp_fire, 1'b1);
        check("b2b_r1_data", last_rsp_data, 32'h00000000);
        check("b2b_r1_tag", last_rsp_tag, 4'd3);
        cyc();
        check("b2b_r2_fire", last_rsp_fire, 1'b1);
        check("b2b_r2_data", last_rsp_data, 32'h00000000);
        check("b2b_r2_tag", last_rsp_tag, 4'd4);
        drain("b2b_drain");

        // Stall with a full queue, then simultaneous pop/issue/accept.
        pulse_reset();
        io_rsp_ready = 1'b0;
        io_cmd_valid = 1'b1;
        set_cmd(32'd10, 32'd4, 2'd1, 4'd11); cyc(); check("fill0_accept", last_cmd_fire, 1'b1);
        set_cmd(32'd20, 32'd4, 2'd0, 4'd12); cyc(); check("fill1_accept", last_cmd_fire, 1'b1);
        set_cmd(32'd30, 32'd3, 2'd2, 4'd13); cyc(); check("fill2_accept", last_cmd_fire, 1'b1);
        set_cmd(32'd40, 32'd1, 2'd0, 4'd14); cyc();
        check("full_ready", last_ready, 1'b0);
        check("full_accept", last_cmd_fire, 1'b0);
        check("full_issued", io_issued, 16'd2);
        check("full_alu_A_held", io_alu_A, 32'd30);
        check("full_alu_op_held", io_alu_op, 2'd2);
        io_rsp_ready = 1'b1;
        cyc();
        check("simul_accept", last_cmd_fire, 1'b1);
        check("simul_pop", last_rsp_fire, 1'b1);
        check("simul_issued", io_issued, 16'd3);
        drain("full_drain");
        check("full_issued_final", io_issued, 16'd4);

        // Randomized traffic against the scoreboard.
        pulse_reset();
        for (int c = 0; c < 400; c++) begin
            io_cmd_valid = ($urandom_range(0, 3) != 0);
            io_rsp_ready = (c % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       io_cmd_A = 32'hFFFFFFFF;
                1:       io_cmd_A = 32'h80000000;
                default: io_cmd_A = $urandom;
            endcase
            io_cmd_B   = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            io_cmd_op  = 2'($urandom_range(0, 3));
            io_cmd_tag = TAG_W'($urandom);
            cyc();
        end
        drain("rand_drain");
        check("rand_issued", io_issued, 16'(cmd_fires));

        // Reset with three commands in flight.
        io_rsp_ready = 1'b0;
        io_cmd_valid = 1'b1;
        set_cmd(32'd1, 32'd1, 2'd0, 4'd1); cyc();
        set_cmd(32'd2, 32'd2, 2'd0, 4'd2); cyc();
        set_cmd(32'd3, 32'd3, 2'd0, 4'd3); cyc();
        io_cmd_valid = 1'b0;
        check("pre_rst_rsp_valid", io_rsp_valid, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("async_rsp_valid", io_rsp_valid, 1'b0);
        check("async_issued", io_issued, 16'd0);
        check("async_alu_A", io_alu_A, 32'd0);
        check("async_alu_B", io_alu_B, 32'd0);
        check("async_cmd_ready", io_cmd_ready, 1'b1);
        exp_q.delete();
        hold_pend = 0;
        cmd_fires = 0;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        io_rsp_ready = 1'b1;
        repeat (4) cyc();
        check("post_rst_rsp_valid", io_rsp_valid, 1'b0);
        check("post_rst_issued", io_issued, 16'd0);
        check("post_rst_cmd_ready", io_cmd_ready, 1'b1);

        // Issue counter wrap: 65537 adds leave the count at 1.
        pulse_reset();
        sb_on = 0;
        io_rsp_ready = 1'b1;
        io_cmd_valid = 1'b1;
        set_cmd(32'd1, 32'd2, 2'd0, 4'd0);
        for (int c = 0; c < 70000 && cmd_fires < 65537; c++) cyc();
        io_cmd_valid = 1'b0;
        check("wrap_accepts", cmd_fires, 65537);
        repeat (3) cyc();
        check("wrap_issued", io_issued, 16'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_issuer.md
ALU_ISSUER -- requirements
Module: alu_issuer

Interface
REQ-001 Parameter: TAG_W, 4, width of command/response tag.
REQ-002 Parameter: RSP_DEPTH, 2, response FIFO entries.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 io_cmd_valid  input  1  command offered.
REQ-006 io_cmd_ready  output  1  issuer accepts command this cycle.
REQ-007 io_cmd_A / io_cmd_B  input  32 each  operands.
REQ-008 io_cmd_op  input  2  opcode: 0 add, 1 sub, 2 mul, 3 reserved.
REQ-009 io_cmd_tag  input  TAG_W  caller tag, returned with result.
REQ-010 io_alu_A / io_alu_B  output  32 each  operands driven to the external ALU.
REQ-011 io_alu_op  output  2  opcode driven to the external ALU.
REQ-012 io_alu_out  input  32  combinational ALU result for current io_alu_* drive.
REQ-013 io_rsp_valid  output  1  response available.
REQ-014 io_rsp_ready  input  1  consumer takes response.
REQ-015 io_rsp_data / io_rsp_tag  output  32 / TAG_W  result and its tag.
REQ-016 io_issued  output  16  count of commands issued to the ALU.

Function
REQ-017 Command transfer occurs when io_cmd_valid && io_cmd_ready in the same cycle; payload is registered into the issue stage.
REQ-018 Issue stage drives io_alu_A/B/op from its register; when empty, it drives zeros.
REQ-019 Issue completes when issue stage valid and the response FIFO has space or is popped that cycle; io_alu_out and issue tag are then written to the FIFO.
REQ-020 io_cmd_ready = !issue_valid || issue completes this cycle (full throughput, 1 cmd/cycle).
REQ-021 Latency: a command accepted at edge N appears on io_rsp_valid after edge N+1 when the FIFO is empty.
REQ-022 Responses leave in acceptance order; io_rsp_data/io_rsp_tag hold stable while io_rsp_valid && !io_rsp_ready.
REQ-023 Results are passed through unmodified: add/sub wrap mod 2^32, mul returns low 32 bits, op 3 returns 0.
REQ-024 FIFO full and no pop: issue stage stalls, io_cmd_ready = 0, ALU inputs held.
REQ-025 FIFO full with simultaneous pop: issue completes, and a new command is accepted, same cycle.
REQ-026 FIFO empty: io_rsp_valid = 0; no bypass from issue stage to io_rsp_* in the same cycle.
REQ-027 io_issued increments by 1 per completed issue and wraps from 0xFFFF to 0.

Reset
REQ-028 Reset assertion asynchronously clears issue_valid, FIFO pointers/count and io_issued; io_rsp_valid = 0, io_alu_* = 0, io_cmd_ready = 1 after release.
REQ-029 Reset mid-operation discards in-flight commands and queued responses; none reappear after release.

Structure
REQ-030 Shared package alu_pkg holds the opcode constants (ADD=0, SUB=1, MUL=2, RSV=3) and the 32-bit data-width constant.
REQ-031 The response buffer is a sub-module rsp_fifo (RSP_DEPTH entries, push/pop/full/empty, same clock/reset); the issue stage and counter stay in alu_issuer.

Verification (bench instantiates the team's ALU as the external ALU)
REQ-032 cmd A=5, B=3, op=0, tag=1, rsp_ready=1 -> rsp_data=8, tag=1 two edges after acceptance; io_issued=1.
REQ-033 Back-to-back cmds sub(3,5), mul(0x10000,0x10000), op3(7,7) with tags 2,3,4 -> rsp 0xFFFFFFFE, 0x00000000, 0x00000000 in order, one per cycle.
REQ-034 rsp_ready=0, send 4 cmds -> 2 in FIFO, 1 in issue stage, cmd_ready=0 on 4th; raising rsp_ready drains all 4 in order, no loss or duplication.
REQ-035 FIFO full, rsp_ready=1 and cmd_valid=1 same cycle -> pop, issue and accept all occur in that cycle.
REQ-036 Assert reset with 3 commands in flight -> outputs cleared immediately; after release, rsp_valid=0, io_issued=0, cmd_ready=1.
REQ-037 Issue 65537 adds -> io_issued=1 after wrap.
